// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: holds one word from a single valid/ready producer and
// hands it to one of 2**N consumer lanes sharing a data bus. Each new word is
// sent to the next enabled lane in round-robin order.
module demux_rr_dispatcher #(
  parameter int N  = 3,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [W-1:0]        in_data,
  output logic                in_ready,
  input  logic [(1<<N)-1:0]   en_mask,
  input  logic [(1<<N)-1:0]   out_ready,
  output logic [(1<<N)-1:0]   out_valid,
  output logic [W-1:0]        out_data,
  output logic [N-1:0]        sel,
  output logic [CW-1:0]       disp_cnt
);

  localparam int NO = 1 << N;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   ptr;
  logic [N-1:0]   nxt;
  logic [N-1:0]   idx;
  logic           found;
  logic           full;
  logic           any_en;
  logic           out_fire;
  logic           in_fire;
  logic [NO-1:0]  lane_one;

  assign full     = (state == HOLD);
  assign any_en   = |en_mask;
  assign out_fire = full & out_ready[sel];
  assign in_ready = any_en & (~full | out_fire);
  assign in_fire  = in_valid & in_ready;
  assign lane_one = {{(NO-1){1'b0}}, 1'b1};

  // Round-robin pick: first enabled lane at or after ptr, wrapping modulo 2**N.
  always_comb begin
    nxt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NO; i++) begin
      idx = ptr + N'(i);
      if (!found && en_mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs; a capture may replace a word leaving in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= '0;
      disp_cnt  <= '0;
    end else begin
      if (in_fire) begin
        state     <= HOLD;
        out_data  <= in_data;
        sel       <= nxt;
        ptr       <= nxt + N'(1);
        out_valid <= lane_one << nxt;
      end else if (out_fire) begin
        state     <= IDLE;
        out_valid <= '0;
      end
      if (out_fire) begin
        disp_cnt <= disp_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed testbench for demux_rr_dispatcher with hand-computed expectations.
module tb_demux_rr_dispatcher;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  en_mask;
  logic [7:0]  out_ready;
  logic [7:0]  out_valid;
  logic [7:0]  out_data;
  logic [2:0]  sel;
  logic [15:0] disp_cnt;

  int testsRun;
  int testsFailed;

  demux_rr_dispatcher #(.N(3), .W(8), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .en_mask   (en_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .disp_cnt  (disp_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic [7:0] m, input logic [7:0] r);
    in_valid  = v;
    in_data   = d;
    en_mask   = m;
    out_ready = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'hFF, 8'h00);

    // Reset state
    step();
    step();
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_sel", 32'(sel), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_disp_cnt", 32'(disp_cnt), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

    // Round-robin over full mask, back-to-back
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 8'(8'h10 + k), 8'hFF, 8'hFF);
      checkOutput("rr_in_ready", 32'(in_ready), 32'h1);
      step();
      checkOutput("rr_sel", 32'(sel), 32'(k % 8));
      checkOutput("rr_out_valid", 32'(out_valid), 32'(1 << (k % 8)));
      checkOutput("rr_out_data", 32'(out_data), 32'(8'h10 + k));
      checkOutput("rr_disp_cnt", 32'(disp_cnt), 32'(k));
    end
    applyStimulus(1'b0, 8'h00, 8'hFF, 8'hFF);
    step();
    checkOutput("rr_drain_valid", 32'(out_valid), 32'h0);
    checkOutput("rr_final_cnt", 32'(disp_cnt), 32'd9);

    // Sparse mask from a fresh pointer: lanes 0,2,5,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    begin
      logic [2:0] expSel [4];
      expSel[0] = 3'd0; expSel[1] = 3'd2; expSel[2] = 3'd5; expSel[3] = 3'd0;
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1'b1, 8'(8'h20 + k), 8'b0010_0101, 8'hFF);
        step();
        checkOutput("sparse_sel", 32'(sel), 32'(expSel[k]));
        checkOutput("sparse_out_valid", 32'(out_valid), 32'(1 << expSel[k]));
      end
    end
    applyStimulus(1'b0, 8'h00, 8'b0010_0101, 8'hFF);
    step();
    checkOutput("sparse_cnt", 32'(disp_cnt), 32'd4);

    // Backpressure on lane 3
    applyStimulus(1'b1, 8'hA5, 8'h08, 8'hF7);
    step();
    applyStimulus(1'b0, 8'h00, 8'h08, 8'hF7);
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'h08);
      checkOutput("bp_out_data", 32'(out_data), 32'hA5);
      checkOutput("bp_sel", 32'(sel), 32'h3);
      checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
      checkOutput("bp_cnt", 32'(disp_cnt), 32'd4);
      step();
    end
    applyStimulus(1'b0, 8'h00, 8'h08, 8'hFF);
    checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    checkOutput("bp_done_valid", 32'(out_valid), 32'h0);
    checkOutput("bp_done_cnt", 32'(disp_cnt), 32'd5);
    checkOutput("bp_sel_kept", 32'(sel), 32'h3);
    checkOutput("bp_data_kept", 32'(out_data), 32'hA5);

    // Empty mask: nothing captured
    applyStimulus(1'b1, 8'h33, 8'h00, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      checkOutput("mask0_in_ready", 32'(in_ready), 32'h0);
      step();
      checkOutput("mask0_out_valid", 32'(out_valid), 32'h0);
    end

    // Mask change while holding for lane 2 (ptr is 4 here)
    applyStimulus(1'b1, 8'h42, 8'h04, 8'h00);
    step();
    checkOutput("mchg_sel", 32'(sel), 32'h2);
    checkOutput("mchg_out_valid", 32'(out_valid), 32'h04);
    applyStimulus(1'b0, 8'h00, 8'h01, 8'h00);
    step();
    checkOutput("mchg_hold_valid", 32'(out_valid), 32'h04);
    checkOutput("mchg_hold_data", 32'(out_data), 32'h42);
    applyStimulus(1'b1, 8'h55, 8'h01, 8'h04);
    checkOutput("mchg_swap_ready", 32'(in_ready), 32'h1);
    step();
    checkOutput("mchg_next_sel", 32'(sel), 32'h0);
    checkOutput("mchg_next_valid", 32'(out_valid), 32'h01);
    checkOutput("mchg_next_data", 32'(out_data), 32'h55);
    checkOutput("mchg_cnt", 32'(disp_cnt), 32'd6);

    // Reset mid-operation while holding
    applyStimulus(1'b0, 8'h00, 8'h01, 8'h00);
    step();
    rst = 1'b1;
    step();
    checkOutput("mrst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("mrst_sel", 32'(sel), 32'h0);
    checkOutput("mrst_cnt", 32'(disp_cnt), 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h99, 8'h81, 8'hFF);
    step();
    checkOutput("mrst_first_sel", 32'(sel), 32'h0);
    checkOutput("mrst_first_valid", 32'(out_valid), 32'h01);
    checkOutput("mrst_first_data", 32'(out_data), 32'h99);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
